// File: rtl/firebird_wb_queue_pkg.sv
// ---------------------------------------------------------------------------
// firebird_wb_queue_pkg
//
// Purpose : Shared definitions for the write-back queue and its lookup
//           matcher. These are the register-index width, the index type and
//           a helper that recognises the hard-wired zero register.
// Ports   : none (package).
//
// The FIREBIRD_* macros mirror the values in firebird_defines.v. They are
// guarded so that a build which already includes that file keeps its values.
// ---------------------------------------------------------------------------
`ifndef FIREBIRD_REG_SIZE
`define FIREBIRD_REG_SIZE 32
`endif
`ifndef FIREBIRD_WBQ_DEPTH
`define FIREBIRD_WBQ_DEPTH 4
`endif

package firebird_wb_queue_pkg;

    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // x0 is hard-wired to zero, so results aimed at it are never buffered
    // and lookups of it never hit.
    function automatic logic is_x0(input reg_idx_t idx);
        return idx == '0;
    endfunction

endpackage

// File: rtl/firebird_wbq_match.sv
// ---------------------------------------------------------------------------
// firebird_wbq_match
//
// Purpose : Priority matcher for one lookup port of the write-back queue.
//           It finds the youngest valid entry whose destination equals the
//           lookup index.
// Ports   :
//   entry_addr  in  DEPTH x 5     destination index of every slot
//   entry_data  in  DEPTH x XLEN  data of every slot
//   valid_mask  in  DEPTH         slot holds a pending, unwritten result
//   head_ptr    in  PTR_W         slot index of the oldest entry
//   lookup_addr in  5             register index being looked up
//   hit         out 1             some pending entry targets lookup_addr
//   data        out XLEN          data of the youngest such entry, else 0
// ---------------------------------------------------------------------------
module firebird_wbq_match
    import firebird_wb_queue_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][REG_IDX_W-1:0] entry_addr,
    input  logic [DEPTH-1:0][XLEN-1:0]      entry_data,
    input  logic [DEPTH-1:0]                valid_mask,
    input  logic [PTR_W-1:0]                head_ptr,
    input  logic [REG_IDX_W-1:0]            lookup_addr,
    output logic                            hit,
    output logic [XLEN-1:0]                 data
);

    logic [PTR_W-1:0] slot;

    // The scan runs from the oldest slot towards the tail. A later match
    // overwrites an earlier one, so the youngest matching entry wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        slot = head_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_ptr + PTR_W'(k);
            if (valid_mask[slot] && !is_x0(lookup_addr) &&
                entry_addr[slot] == lookup_addr) begin
                hit  = 1'b1;
                data = entry_data[slot];
            end
        end
    end

endmodule

// File: rtl/firebird_wb_queue.sv
// ---------------------------------------------------------------------------
// firebird_wb_queue
//
// Purpose : In-order write-back queue in front of the register file's single
//           write port. Completed results are pushed in and drained at most
//           one per cycle. Two lookup ports let decode bypass the youngest
//           pending value of a register.
// Ports   :
//   clk              in  1       clock, rising edge
//   reset            in  1       asynchronous, active-low reset
//   in_valid         in  1       producer has a result
//   in_ready         out 1       queue can accept (not full)
//   in_addr          in  5       destination register index
//   in_data          in  XLEN    result value
//   drain_en         in  1       permission to write the regfile this cycle
//   we/waddr/wdata   out         regfile write port, driven from the head
//   q1_addr/q2_addr  in  5       lookup indices
//   q1_hit/q2_hit    out 1       lookup index has a pending result
//   q1_data/q2_data  out XLEN    youngest pending value for that index
//   count            out log2(DEPTH)+1  occupied entries
//   empty/full       out 1       occupancy flags
// ---------------------------------------------------------------------------
`ifndef FIREBIRD_REG_SIZE
`define FIREBIRD_REG_SIZE 32
`endif
`ifndef FIREBIRD_WBQ_DEPTH
`define FIREBIRD_WBQ_DEPTH 4
`endif

module firebird_wb_queue
    import firebird_wb_queue_pkg::*;
#(
    parameter int XLEN  = `FIREBIRD_REG_SIZE,
    parameter int DEPTH = `FIREBIRD_WBQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [REG_IDX_W-1:0]       in_addr,
    input  logic [XLEN-1:0]            in_data,
    input  logic                       drain_en,
    output logic                       we,
    output logic [REG_IDX_W-1:0]       waddr,
    output logic [XLEN-1:0]            wdata,
    input  logic [REG_IDX_W-1:0]       q1_addr,
    input  logic [REG_IDX_W-1:0]       q2_addr,
    output logic                       q1_hit,
    output logic                       q2_hit,
    output logic [XLEN-1:0]            q1_data,
    output logic [XLEN-1:0]            q2_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]                head_q, head_d;
    logic [PTR_W-1:0]                tail_q, tail_d;
    logic [CNT_W-1:0]                count_q, count_d;
    logic [DEPTH-1:0][REG_IDX_W-1:0] mem_addr_q, mem_addr_d;
    logic [DEPTH-1:0][XLEN-1:0]      mem_data_q, mem_data_d;

    logic                            push_fire;
    logic                            push_store;
    logic                            pop_fire;
    logic [DEPTH-1:0]                valid_mask;
    logic [PTR_W-1:0]                slot_offset;

    // count is the only source of full/empty, so the pointers may wrap
    // freely. in_ready follows the registered count, which means a pop in a
    // full cycle only frees the slot for the next cycle.
    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign in_ready   = !full;
    assign count      = count_q;

    assign push_fire  = in_valid && in_ready;
    assign push_store = push_fire && !is_x0(in_addr);
    assign pop_fire   = !empty && drain_en;

    // waddr/wdata always show the head slot. Only we is gated.
    assign we         = pop_fire;
    assign waddr      = mem_addr_q[head_q];
    assign wdata      = mem_data_q[head_q];

    // Next-state for the pointers, occupancy and storage. A push aimed at
    // x0 is accepted but leaves no trace.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        if (push_store) begin
            mem_addr_d[tail_q] = in_addr;
            mem_data_d[tail_q] = in_data;
            tail_d             = tail_q + PTR_W'(1);
        end
        if (pop_fire) begin
            head_d = head_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_store) - CNT_W'(pop_fire);
    end

    // A slot is pending when its distance from the head is below the
    // occupancy. This also hides stale slot contents after a reset.
    always_comb begin
        valid_mask  = '0;
        slot_offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_offset   = PTR_W'(i) - head_q;
            valid_mask[i] = {1'b0, slot_offset} < count_q;
        end
    end

    // Control state clears immediately on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Slot contents are never reset. The valid mask and we gating keep
    // them unobservable until they are rewritten.
    always_ff @(posedge clk) begin
        mem_addr_q <= mem_addr_d;
        mem_data_q <= mem_data_d;
    end

    firebird_wbq_match #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_match_q1 (
        .entry_addr  (mem_addr_q),
        .entry_data  (mem_data_q),
        .valid_mask  (valid_mask),
        .head_ptr    (head_q),
        .lookup_addr (q1_addr),
        .hit         (q1_hit),
        .data        (q1_data)
    );

    firebird_wbq_match #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_match_q2 (
        .entry_addr  (mem_addr_q),
        .entry_data  (mem_data_q),
        .valid_mask  (valid_mask),
        .head_ptr    (head_q),
        .lookup_addr (q2_addr),
        .hit         (q2_hit),
        .data        (q2_data)
    );

endmodule
